// File: rtl/mult_seq_pkg.sv
// Shared constants for the multiply sequencer: ALU opcodes, register slot indices
// and the controller state encoding.
package mult_seq_pkg;

   typedef enum logic [2:0] {
      ALU_PASSA = 3'd0,
      ALU_ADD   = 3'd1,
      ALU_SUB   = 3'd2,
      ALU_AND   = 3'd3,
      ALU_OR    = 3'd4,
      ALU_XOR   = 3'd5,
      ALU_INCA  = 3'd6,
      ALU_DECA  = 3'd7
   } alu_op_e;

   localparam int REG_R0   = 0;
   localparam int REG_R1   = 1;
   localparam int REG_R2   = 2;
   localparam int REG_NONE = 3;

   // Every 3-bit code is a named state; the default arm in the top still maps
   // anything unexpected back to IDLE.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOADA = 3'd1,
      ST_LOADB = 3'd2,
      ST_CLR   = 3'd3,
      ST_TEST  = 3'd4,
      ST_ADD   = 3'd5,
      ST_DEC   = 3'd6,
      ST_DONE  = 3'd7
   } state_e;

endpackage

// File: rtl/mult_seq_decode.sv
// Pure combinational state -> datapath control table for the multiply sequencer.
// Bus selects, write destination, ALU opcode, busy and done all derive from state alone.
module mult_seq_decode
   import mult_seq_pkg::*;
#(
   parameter int SELECTIONALU  = 3,
   parameter int SELECTIONDECO = 3,
   parameter int SRC_A_REG     = 6,
   parameter int SRC_B_REG     = 7
) (
   input  state_e                    state,
   output logic [SELECTIONDECO-1:0]  sel_a,
   output logic [SELECTIONDECO-1:0]  sel_b,
   output logic [SELECTIONDECO-1:0]  sel_c,
   output logic [SELECTIONALU-1:0]   sel_alu,
   output logic                      busy,
   output logic                      done
);

   localparam logic [SELECTIONDECO-1:0] R_SRC_A = SELECTIONDECO'(SRC_A_REG);
   localparam logic [SELECTIONDECO-1:0] R_SRC_B = SELECTIONDECO'(SRC_B_REG);
   localparam logic [SELECTIONDECO-1:0] R_0     = SELECTIONDECO'(REG_R0);
   localparam logic [SELECTIONDECO-1:0] R_1     = SELECTIONDECO'(REG_R1);
   localparam logic [SELECTIONDECO-1:0] R_2     = SELECTIONDECO'(REG_R2);
   localparam logic [SELECTIONDECO-1:0] R_NONE  = SELECTIONDECO'(REG_NONE);

   localparam logic [SELECTIONALU-1:0] OP_PASSA = SELECTIONALU'(ALU_PASSA);
   localparam logic [SELECTIONALU-1:0] OP_ADD   = SELECTIONALU'(ALU_ADD);
   localparam logic [SELECTIONALU-1:0] OP_XOR   = SELECTIONALU'(ALU_XOR);
   localparam logic [SELECTIONALU-1:0] OP_DECA  = SELECTIONALU'(ALU_DECA);

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_c   = R_NONE;
      sel_alu = OP_PASSA;
      done    = 1'b0;
      case (state)
         ST_LOADA: begin sel_a = R_SRC_A; sel_c = R_0; end
         ST_LOADB: begin sel_a = R_SRC_B; sel_c = R_1; end
         // R0 xor R0 is the cheapest way to produce a zero to clear the accumulator
         ST_CLR:   begin sel_a = R_0; sel_b = R_0; sel_c = R_2; sel_alu = OP_XOR; end
         ST_TEST:  begin sel_a = R_1; end
         ST_ADD:   begin sel_a = R_2; sel_b = R_0; sel_c = R_2; sel_alu = OP_ADD; end
         ST_DEC:   begin sel_a = R_1; sel_c = R_1; sel_alu = OP_DECA; end
         ST_DONE:  begin done = 1'b1; end
         default:  ;
      endcase
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: rtl/mult_sequencer.sv
// Multiply-by-repeated-addition controller for the 8-bit regfile/ALU datapath.
// Define MULT_SEQ_OVF_EN to build the sticky accumulation-overflow flag sOvf.
module mult_sequencer
   import mult_seq_pkg::*;
#(
   parameter int SELECTIONALU  = 3,
   parameter int SELECTIONDECO = 3,
   parameter int SRC_A_REG     = 6,
   parameter int SRC_B_REG     = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sStart,
   input  logic                      sZero,
   input  logic                      sCarry,
   output logic [SELECTIONDECO-1:0]  sSelDecoA,
   output logic [SELECTIONDECO-1:0]  sSelDecoB,
   output logic [SELECTIONDECO-1:0]  sSelDecoC,
   output logic [SELECTIONALU-1:0]   sSelAlu,
   output logic                      sBusy,
   output logic                      sDone,
   output logic                      sOvf,
   output logic [2:0]                dbg_state
);

   state_e state_q, state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (sStart) state_d = ST_LOADA;
         ST_LOADA: state_d = ST_LOADB;
         ST_LOADB: state_d = ST_CLR;
         ST_CLR:   state_d = ST_TEST;
         ST_TEST:  state_d = sZero ? ST_DONE : ST_ADD;
         ST_ADD:   state_d = ST_DEC;
         ST_DEC:   state_d = ST_TEST;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   mult_seq_decode #(
      .SELECTIONALU  (SELECTIONALU),
      .SELECTIONDECO (SELECTIONDECO),
      .SRC_A_REG     (SRC_A_REG),
      .SRC_B_REG     (SRC_B_REG)
   ) u_decode (
      .state   (state_q),
      .sel_a   (sSelDecoA),
      .sel_b   (sSelDecoB),
      .sel_c   (sSelDecoC),
      .sel_alu (sSelAlu),
      .busy    (sBusy),
      .done    (sDone)
   );

   assign dbg_state = state_q;

`ifdef MULT_SEQ_OVF_EN
   logic ovf_q, ovf_d;

   // Cleared as the operands load, then sticky across the whole accumulation and DONE/IDLE.
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == ST_LOADA)                ovf_d = 1'b0;
      else if (state_q == ST_ADD && sCarry)   ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign sOvf = ovf_q;
`else
   logic unused_carry;
   assign unused_carry = sCarry;
   assign sOvf = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: behavioural regfile/ALU around the DUT plus a run-schedule
// reference model checked every cycle, and directed literal checks of the key scenarios.
module tb_mult_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_start = 1'b0;
   logic       s_zero, s_carry;
   logic [2:0] sel_a, sel_b, sel_c, sel_alu;
   logic       s_busy, s_done, s_ovf;
   logic [2:0] dbg_state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mult_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .sStart    (s_start),
      .sZero     (s_zero),
      .sCarry    (s_carry),
      .sSelDecoA (sel_a),
      .sSelDecoB (sel_b),
      .sSelDecoC (sel_c),
      .sSelAlu   (sel_alu),
      .sBusy     (s_busy),
      .sDone     (s_done),
      .sOvf      (s_ovf),
      .dbg_state (dbg_state)
   );

   // ---------------- datapath environment: register file + ALU ----------------
   logic [7:0] rf [0:7];
   logic       load_en = 1'b0;
   logic [7:0] load_r6 = 8'd0, load_r7 = 8'd0;
   logic [7:0] alu_a, alu_b;
   logic [8:0] alu_res;

   always_comb begin
      alu_a = rf[sel_a];
      alu_b = rf[sel_b];
      case (sel_alu)
         3'd0: alu_res = {1'b0, alu_a};
         3'd1: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
         3'd2: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
         3'd3: alu_res = {1'b0, alu_a & alu_b};
         3'd4: alu_res = {1'b0, alu_a | alu_b};
         3'd5: alu_res = {1'b0, alu_a ^ alu_b};
         3'd6: alu_res = {1'b0, alu_a} + 9'd1;
         default: alu_res = {1'b0, alu_a} - 9'd1;
      endcase
   end

   assign s_zero  = (alu_res[7:0] == 8'd0);
   assign s_carry = alu_res[8];

   always @(posedge clk) begin
      if (load_en) begin
         rf[6] <= load_r6;
         rf[7] <= load_r7;
      end
      if (sel_c != 3'd3) rf[sel_c] <= alu_res[7:0];
   end

   // ---------------- reference model: run schedule by cycle offset ----------------
   // m_off = 0 means idle; otherwise the cycle's position within the current run.
   int         m_off = 0;
   int         m_ra = 0, m_rb = 0;
   logic       m_hold = 1'b0;
   logic       m_valid = 1'b0;
   logic [7:0] exp_q [$];

   always @(posedge clk) begin
      if (rst) begin
         m_off   <= 0;
         m_hold  <= 1'b0;
         m_valid <= 1'b1;
         exp_q.delete();
      end else if (m_valid) begin
         if (m_off == 0) begin
            if (s_start) begin
               m_off <= 1;
               m_ra  <= int'(rf[6]);
               m_rb  <= int'(rf[7]);
               exp_q.push_back(8'((int'(rf[6]) * int'(rf[7])) % 256));
            end
         end else if (m_off == 5 + 3 * m_rb) begin
            m_off  <= 0;
            m_hold <= (m_ra * m_rb > 255);
         end else begin
            m_off <= m_off + 1;
         end
      end
   end

   // ---------------- compare process ----------------
   logic [2:0] e_a, e_b, e_c, e_alu;
   logic       e_busy, e_done, e_ovf;
   int         nd;
   logic [7:0] e_res;

   always @(negedge clk) begin
      if (m_valid) begin
         e_a = 3'd0; e_b = 3'd0; e_c = 3'd3; e_alu = 3'd0;
         e_busy = (m_off != 0);
         e_done = 1'b0;
         if (m_off == 1) begin
            e_a = 3'd6; e_c = 3'd0;
         end else if (m_off == 2) begin
            e_a = 3'd7; e_c = 3'd1;
         end else if (m_off == 3) begin
            e_c = 3'd2; e_alu = 3'd5;
         end else if (m_off != 0 && m_off == 5 + 3 * m_rb) begin
            e_done = 1'b1;
         end else if (m_off >= 4) begin
            case ((m_off - 4) % 3)
               0: e_a = 3'd1;
               1: begin e_a = 3'd2; e_b = 3'd0; e_c = 3'd2; e_alu = 3'd1; end
               default: begin e_a = 3'd1; e_c = 3'd1; e_alu = 3'd7; end
            endcase
         end
`ifdef MULT_SEQ_OVF_EN
         if (m_off <= 1) e_ovf = m_hold;
         else begin
            nd = (m_off >= 3) ? (m_off - 3) / 3 : 0;
            if (nd > m_rb) nd = m_rb;
            e_ovf = (nd * m_ra > 255);
         end
`else
         e_ovf = 1'b0;
`endif
         checks++;
         if ({sel_a, sel_b, sel_c, sel_alu, s_busy, s_done, s_ovf} !==
             {e_a, e_b, e_c, e_alu, e_busy, e_done, e_ovf}) begin
            failures++;
            $display("FAIL outputs t=%0t off=%0d got a=%0d b=%0d c=%0d alu=%0d busy=%b done=%b ovf=%b expected a=%0d b=%0d c=%0d alu=%0d busy=%b done=%b ovf=%b",
                     $time, m_off, sel_a, sel_b, sel_c, sel_alu, s_busy, s_done, s_ovf,
                     e_a, e_b, e_c, e_alu, e_busy, e_done, e_ovf);
         end
         if (e_done) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL result_queue t=%0t got empty expected one pending result", $time);
            end else begin
               e_res = exp_q.pop_front();
               if (rf[2] !== e_res || rf[1] !== 8'd0) begin
                  failures++;
                  $display("FAIL result t=%0t got R2=%0h R1=%0h expected R2=%0h R1=0", $time, rf[2], rf[1], e_res);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic void chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endfunction

   task automatic load_ops(input logic [7:0] r6, input logic [7:0] r7);
      @(negedge clk);
      load_en = 1'b1; load_r6 = r6; load_r7 = r7;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (s_busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("idle_timeout", int'(s_busy), 0);
   endtask

   // Pulse sStart, then watch cycles 1..win; extra pulses land in cycles x1/x2.
   task automatic run_once(input int x1, input int x2, input int win,
                           output int done_cyc, output int n_done);
      done_cyc = -1;
      n_done = 0;
      @(negedge clk);
      s_start = 1'b1;
      for (int n = 1; n <= win; n++) begin
         @(negedge clk);
         if (s_done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = n;
         end
         s_start = (n == x1 || n == x2);
      end
      s_start = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   int dc, ndn, idle_cnt;
   int dcyc [3];

   initial begin
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_sel_a", int'(sel_a), 0);
      chk("reset_sel_b", int'(sel_b), 0);
      chk("reset_sel_c", int'(sel_c), 3);
      chk("reset_alu", int'(sel_alu), 0);
      chk("reset_busy", int'(s_busy), 0);
      chk("reset_done", int'(s_done), 0);
      chk("reset_ovf", int'(s_ovf), 0);
      rst = 1'b0;

      // 4 * 5
      load_ops(8'd4, 8'd5);
      run_once(0, 0, 22, dc, ndn);
      chk("t1_done_cycle", dc, 20);
      chk("t1_done_count", ndn, 1);
      chk("t1_r2", int'(rf[2]), 8'h14);
      chk("t1_r1", int'(rf[1]), 0);
      chk("t1_ovf", int'(s_ovf), 0);

      // multiplier zero
      load_ops(8'd9, 8'd0);
      run_once(0, 0, 7, dc, ndn);
      chk("t2_done_cycle", dc, 5);
      chk("t2_r2", int'(rf[2]), 0);

      // 0x40 * 5 wraps
      load_ops(8'h40, 8'd5);
      run_once(0, 0, 22, dc, ndn);
      chk("t3_done_cycle", dc, 20);
      chk("t3_r2", int'(rf[2]), 8'h40);
`ifdef MULT_SEQ_OVF_EN
      chk("t3_ovf", int'(s_ovf), 1);
`else
      chk("t3_ovf", int'(s_ovf), 0);
`endif

      // start pulses while busy are ignored
      load_ops(8'd4, 8'd5);
      run_once(3, 10, 24, dc, ndn);
      chk("t4_done_cycle", dc, 20);
      chk("t4_done_count", ndn, 1);
      chk("t4_r2", int'(rf[2]), 8'h14);
      chk("t4_idle_after", int'(s_busy), 0);

      // reset in cycle 8 aborts the run
      @(negedge clk);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_busy", int'(s_busy), 0);
      chk("t5_sel_c", int'(sel_c), 3);
      chk("t5_done", int'(s_done), 0);
      run_once(0, 0, 22, dc, ndn);
      chk("t5_done_cycle", dc, 20);
      chk("t5_r2", int'(rf[2]), 8'h14);

      // sStart held high: back-to-back runs
      ndn = 0;
      idle_cnt = 0;
      @(negedge clk);
      s_start = 1'b1;
      for (int n = 1; n <= 66; n++) begin
         @(negedge clk);
         if (s_done) begin
            if (ndn < 3) dcyc[ndn] = n;
            ndn++;
         end
         if (!s_busy && n <= 62) idle_cnt++;
      end
      s_start = 1'b0;
      chk("t6_done_count", ndn, 3);
      chk("t6_first_done", dcyc[0], 20);
      chk("t6_gap1", dcyc[1] - dcyc[0], 21);
      chk("t6_gap2", dcyc[2] - dcyc[1], 21);
      chk("t6_idle_cycles", idle_cnt, 2);
      wait_idle();

      // randomized runs with noisy sStart and occasional reset
      for (int it = 0; it < 30; it++) begin
         int span, rst_at;
         logic do_rst;
         load_ops(8'($urandom_range(0, 255)), 8'($urandom_range(0, 9)));
         span   = 5 + 3 * int'(rf[7]) + 2;
         do_rst = ($urandom_range(0, 5) == 0);
         rst_at = $urandom_range(1, span);
         @(negedge clk);
         s_start = 1'b1;
         for (int n = 1; n <= span; n++) begin
            @(negedge clk);
            s_start = ($urandom_range(0, 3) == 0);
            rst     = do_rst && (n == rst_at);
         end
         @(negedge clk);
         s_start = 1'b0;
         rst     = 1'b0;
         wait_idle();
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL global_timeout got=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
